// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command path: sync/command codes, packet FSM states
// and the packet checksum rule. The game FSM imports the same command codes.
package uart_cmd_ctrl_pkg;

  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] SYNC_BYTE   = 8'hA5;
  localparam logic [DATA_W-1:0] CMD_DIR     = 8'h01;  // arg 0..3 = up/right/down/left
  localparam logic [DATA_W-1:0] CMD_PAUSE   = 8'h02;
  localparam logic [DATA_W-1:0] CMD_RESTART = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_ARG,
    ST_CHK
  } state_t;

  function automatic logic [DATA_W-1:0] pkt_chk(input logic [DATA_W-1:0] cmd,
                                                input logic [DATA_W-1:0] arg);
    return SYNC_BYTE ^ cmd ^ arg;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bus between uart_rx / game FSM and the command controller.
// master = controller side, slave = its environment (uart_rx plus command consumer).
interface uart_cmd_ctrl_if;
  import uart_cmd_ctrl_pkg::*;

  logic              baud_tick;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_frame_err;
  logic [DATA_W-1:0] cmd;
  logic [DATA_W-1:0] arg;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        err_cnt;
  logic [7:0]        drop_cnt;

  modport master (
    output baud_tick, cmd, arg, cmd_valid, err_cnt, drop_cnt,
    input  rx_data, rx_valid, rx_frame_err, cmd_ready
  );

  modport slave (
    input  baud_tick, cmd, arg, cmd_valid, err_cnt, drop_cnt,
    output rx_data, rx_valid, rx_frame_err, cmd_ready
  );

endinterface

// File: rtl/uart_cmd_ctrl_baud_gen.sv
// Free-running 16x baud tick generator: one-cycle pulse every DIV clocks.
module uart_baud_gen #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_baud_gen: DIV must be at least 2");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command packet controller: assembles {SYNC, CMD, ARG, CHK} packets from uart_rx,
// hands validated commands to the game FSM through a one-entry holding register.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int BAUD          = 115200,
  parameter int TIMEOUT_TICKS = 480
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_cmd_ctrl_if.master bus
);

  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int TW  = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_TICKS - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
    return (en && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

  logic              tick;
  state_t            state_p0, state_nxt;
  logic [DATA_W-1:0] cmd_p0, arg_p0;
  logic [TW-1:0]     tout_p0;
  logic              frame_err_p1;
  logic [DATA_W-1:0] cmd_p1, arg_p1;
  logic              vld_p1;
  logic [7:0]        err_q, drop_q;

  logic err_evt, err_inc, drop_inc, push, pop;
  logic ld_cmd, ld_arg, tout_clr, tout_inc;

  uart_baud_gen #(.DIV(DIV)) u_baud_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign err_evt  = bus.rx_frame_err & ~frame_err_p1;
  assign pop      = vld_p1 & bus.cmd_ready;
  assign drop_inc = push & vld_p1 & ~bus.cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_p0 <= ST_IDLE;
    else        state_p0 <= state_nxt;
  end

  // Error events outrank bytes, and bytes outrank the timeout tick.
  always_comb begin
    state_nxt = state_p0;
    err_inc   = 1'b0;
    push      = 1'b0;
    ld_cmd    = 1'b0;
    ld_arg    = 1'b0;
    tout_clr  = 1'b0;
    tout_inc  = 1'b0;
    if (err_evt) begin
      if (state_p0 != ST_IDLE) begin
        state_nxt = ST_IDLE;
        err_inc   = 1'b1;
      end
    end else if (bus.rx_valid) begin
      tout_clr = 1'b1;
      unique case (state_p0)
        ST_IDLE: if (bus.rx_data == SYNC_BYTE) state_nxt = ST_CMD;
        ST_CMD: begin
          ld_cmd    = 1'b1;
          state_nxt = ST_ARG;
        end
        ST_ARG: begin
          ld_arg    = 1'b1;
          state_nxt = ST_CHK;
        end
        ST_CHK: begin
          if (bus.rx_data == pkt_chk(cmd_p0, arg_p0)) push = 1'b1;
          else                                        err_inc = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if ((state_p0 != ST_IDLE) && tick) begin
      if (tout_p0 == TOUT_LAST) begin
        state_nxt = ST_IDLE;
        err_inc   = 1'b1;
      end else begin
        tout_inc = 1'b1;
      end
    end
    if (state_nxt == ST_IDLE) tout_clr = 1'b1;
  end

  // Packet assembly stage (p0) feeding the holding register stage (p1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_p1 <= 1'b0;
      cmd_p0       <= '0;
      arg_p0       <= '0;
      tout_p0      <= '0;
      cmd_p1       <= '0;
      arg_p1       <= '0;
      vld_p1       <= 1'b0;
      err_q        <= '0;
      drop_q       <= '0;
    end else begin
      frame_err_p1 <= bus.rx_frame_err;
      if (ld_cmd) cmd_p0 <= bus.rx_data;
      if (ld_arg) arg_p0 <= bus.rx_data;
      if (tout_clr)      tout_p0 <= '0;
      else if (tout_inc) tout_p0 <= tout_p0 + 1'b1;
      if (push) begin
        if (!vld_p1 || bus.cmd_ready) begin
          cmd_p1 <= cmd_p0;
          arg_p1 <= arg_p0;
          vld_p1 <= 1'b1;
        end
      end else if (pop) begin
        vld_p1 <= 1'b0;
      end
      err_q  <= sat_inc(err_q, err_inc);
      drop_q <= sat_inc(drop_q, drop_inc);
    end
  end

  assign bus.baud_tick = tick;
  assign bus.cmd       = cmd_p1;
  assign bus.arg       = arg_p1;
  assign bus.cmd_valid = vld_p1;
  assign bus.err_cnt   = err_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed scenarios plus random traffic checked each cycle
// against a packet-level reference model.
module tb_uart_cmd_ctrl;
  import uart_cmd_ctrl_pkg::*;

  localparam int DIV     = 54;
  localparam int TIMEOUT = 480;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_ctrl_if bus ();

  uart_cmd_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int tick_seen = 0;
  bit rand_ready = 0;

  // reference model state
  logic [7:0] pkt[$];
  int         m_ticks, m_err, m_drop;
  bit         m_vld, m_prev_fe;
  logic [7:0] m_cmd, m_arg;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    pkt.delete();
    m_ticks = 0; m_err = 0; m_drop = 0;
    m_vld = 0; m_prev_fe = 0; m_cmd = 8'h00; m_arg = 8'h00;
  endtask

  task automatic model_step();
    bit tick_now, err_evt, push, pop;
    logic [7:0] pc, pa;
    tick_now = (cyc % DIV) == (DIV - 1);
    err_evt  = bus.rx_frame_err && !m_prev_fe;
    m_prev_fe = bus.rx_frame_err;
    pop  = m_vld && bus.cmd_ready;
    push = 0;
    pc = 8'h00; pa = 8'h00;
    if (err_evt) begin
      if (pkt.size() > 0) m_err = (m_err < 255) ? m_err + 1 : 255;
      pkt.delete();
      m_ticks = 0;
    end else if (bus.rx_valid) begin
      m_ticks = 0;
      if (pkt.size() > 0 || bus.rx_data == 8'hA5) pkt.push_back(bus.rx_data);
      if (pkt.size() == 4) begin
        if (pkt[3] == (pkt[0] ^ pkt[1] ^ pkt[2])) begin
          push = 1; pc = pkt[1]; pa = pkt[2];
        end else begin
          m_err = (m_err < 255) ? m_err + 1 : 255;
        end
        pkt.delete();
      end
    end else if (pkt.size() > 0 && tick_now) begin
      m_ticks++;
      if (m_ticks >= TIMEOUT) begin
        m_err = (m_err < 255) ? m_err + 1 : 255;
        pkt.delete();
        m_ticks = 0;
      end
    end
    if (push) begin
      if (!m_vld || pop) begin
        m_cmd = pc; m_arg = pa; m_vld = 1;
      end else begin
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
    end else if (pop) begin
      m_vld = 0;
    end
  endtask

  task automatic cycle();
    if (rand_ready) bus.cmd_ready = 1'($urandom_range(0, 1));
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.baud_tick) tick_seen++;
    check_eq("baud_tick", bus.baud_tick, ((cyc % DIV) == (DIV - 1)));
    check_eq("cmd_valid", bus.cmd_valid, m_vld);
    check_eq("cmd", bus.cmd, m_cmd);
    check_eq("arg", bus.arg, m_arg);
    check_eq("err_cnt", bus.err_cnt, m_err);
    check_eq("drop_cnt", bus.drop_cnt, m_drop);
  endtask

  task automatic do_reset();
    bus.rx_valid = 0;
    bus.rx_frame_err = 0;
    bus.rx_data = 8'h00;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_baud_tick", bus.baud_tick, 0);
    check_eq("rst_cmd_valid", bus.cmd_valid, 0);
    check_eq("rst_cmd", bus.cmd, 0);
    check_eq("rst_arg", bus.arg, 0);
    check_eq("rst_err_cnt", bus.err_cnt, 0);
    check_eq("rst_drop_cnt", bus.drop_cnt, 0);
    rst_n = 1;
    cyc = 0;
    model_clear();
  endtask

  task automatic send(input logic [7:0] d);
    bus.rx_data = d;
    bus.rx_valid = 1;
    cycle();
    bus.rx_valid = 0;
    cycle();
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    send(SYNC_BYTE);
    send(c);
    send(a);
    send(k);
  endtask

  initial begin
    bus.cmd_ready = 1;
    do_reset();

    // baud generator alone
    tick_seen = 0;
    repeat (1000) cycle();
    check_eq("tick_count_1000", tick_seen, 18);

    // good packet, consumer ready
    send(SYNC_BYTE); send(CMD_DIR); send(8'h02);
    bus.rx_data = 8'hA6; bus.rx_valid = 1;
    cycle();
    bus.rx_valid = 0;
    check_eq("good_valid", bus.cmd_valid, 1);
    check_eq("good_cmd", bus.cmd, 8'h01);
    check_eq("good_arg", bus.arg, 8'h02);
    cycle();
    check_eq("good_err", bus.err_cnt, 0);
    check_eq("good_drop", bus.drop_cnt, 0);

    // bad checksum, then recovery
    send_pkt(8'h01, 8'h02, 8'h00);
    check_eq("badchk_err", bus.err_cnt, 1);
    check_eq("badchk_valid", bus.cmd_valid, 0);
    send_pkt(CMD_RESTART, 8'h00, 8'hA6);
    check_eq("after_bad_err", bus.err_cnt, 1);

    // full holding register: drop, then push coinciding with pop
    bus.cmd_ready = 0;
    send_pkt(CMD_DIR, 8'h00, 8'hA4);
    send_pkt(CMD_PAUSE, 8'h00, 8'hA7);
    check_eq("hold_cmd", bus.cmd, 8'h01);
    check_eq("hold_drop", bus.drop_cnt, 1);
    send(SYNC_BYTE); send(CMD_RESTART); send(8'h00);
    bus.cmd_ready = 1;
    bus.rx_data = 8'hA6; bus.rx_valid = 1;
    cycle();
    bus.rx_valid = 0;
    check_eq("pushpop_valid", bus.cmd_valid, 1);
    check_eq("pushpop_cmd", bus.cmd, 8'h03);
    check_eq("pushpop_drop", bus.drop_cnt, 1);
    cycle();

    // inter-byte timeout
    do_reset();
    send(SYNC_BYTE); send(CMD_DIR);
    repeat (TIMEOUT * DIV + 60) cycle();
    check_eq("timeout_err", bus.err_cnt, 1);
    send_pkt(CMD_PAUSE, 8'h00, 8'hA7);
    check_eq("timeout_recover_cmd", bus.cmd, 8'h02);

    // frame errors: one count per rising edge, saturation
    do_reset();
    send(SYNC_BYTE); send(CMD_DIR);
    bus.rx_frame_err = 1;
    cycle();
    check_eq("fe_err", bus.err_cnt, 1);
    repeat (5) cycle();
    check_eq("fe_held_err", bus.err_cnt, 1);
    bus.rx_frame_err = 0;
    cycle();
    for (int i = 0; i < 300; i++) begin
      send(SYNC_BYTE);
      bus.rx_frame_err = 1;
      cycle();
      bus.rx_frame_err = 0;
      cycle();
    end
    check_eq("err_saturated", bus.err_cnt, 8'hFF);

    // reset mid-packet discards the partial packet
    send(SYNC_BYTE); send(CMD_DIR);
    do_reset();
    send(8'h02); send(8'hA6);
    check_eq("midrst_valid", bus.cmd_valid, 0);

    // random traffic
    rand_ready = 1;
    for (int it = 0; it < 3000; it++) begin
      logic [7:0] c, a, k;
      c = 8'($urandom); a = 8'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          k = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pkt_chk(c, a);
          send_pkt(c, a, k);
        end
        5: send(8'($urandom));
        6: begin
          bus.rx_frame_err = 1;
          repeat ($urandom_range(1, 3)) cycle();
          bus.rx_frame_err = 0;
          cycle();
        end
        7: begin
          bus.rx_data = c; bus.rx_valid = 1; bus.rx_frame_err = 1;
          cycle();
          bus.rx_valid = 0; bus.rx_frame_err = 0;
          cycle();
        end
        8: repeat ($urandom_range(0, 40)) cycle();
        default: begin
          k = pkt_chk(c, a);
          bus.rx_valid = 1;
          bus.rx_data = SYNC_BYTE; cycle();
          bus.rx_data = c; cycle();
          bus.rx_data = a; cycle();
          bus.rx_data = k; cycle();
          bus.rx_valid = 0;
          cycle();
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
